// File: rtl/eep_pkg.sv
// Shared types and constants for the EEPROM write scheduler.
package eep_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StBus,
    StChrg,
    StVrfy,
    StDone
  } state_e;

  localparam int unsigned DW_DEFAULT      = 12;
  localparam int unsigned CHRG_CYCLES_3MS = 12000;

endpackage

// File: rtl/eep_rr_arb.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping to 0.
module eep_rr_arb #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IW-1:0]    pick_idx
);

  logic          found;
  int unsigned   pos;
  logic [IW-1:0] k;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    pos      = 0;
    k        = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      pos = (32'(ptr) + off) % N_REQ;
      k   = IW'(pos);
      if (!found && req[k]) begin
        found    = 1'b1;
        pick[k]  = 1'b1;
        pick_idx = k;
      end
    end
  end

endmodule

// File: rtl/eep_wr_sched.sv
// EEPROM write scheduler: round-robin grant, one bus write cycle, then a charge-pump window.
// Optional read-back check after the pump window is enabled by EEP_RDBK_VERIFY_EN.
module eep_wr_sched
  import eep_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned DW          = DW_DEFAULT,
  parameter int unsigned CHRG_CYCLES = CHRG_CYCLES_3MS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] wdata,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    done,
  output logic                err,
  output logic                busy,
  output logic                eep_cs_n,
  output logic                eep_r_w_n,
  inout  logic [DW-1:0]       eep_bus,
  output logic                chrg_pmp_en
);

  localparam int unsigned IW       = $clog2(N_REQ);
  localparam int unsigned TW       = $clog2(CHRG_CYCLES + 1);
  localparam logic [TW-1:0] ChrgLast = TW'(CHRG_CYCLES - 1);
  localparam logic [IW-1:0] LastIdx  = IW'(N_REQ - 1);

  state_e            state_q;
  logic [TW-1:0]     timer_q;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     gidx_q;
  logic [IW-1:0]     idx_q;
  logic [DW-1:0]     data_q;
  logic [N_REQ-1:0]  gnt_q;
  logic [N_REQ-1:0]  done_q;
  logic              busy_q;
  logic              cs_n_q;
  logic              r_w_n_q;
  logic              bus_oe_q;
  logic              pmp_q;
  logic [N_REQ-1:0]  arb_pick;
  logic [IW-1:0]     arb_idx;
  logic [N_REQ-1:0]  idx_oh;

  eep_rr_arb #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_arb (
    .req      (req),
    .ptr      (ptr_q),
    .pick     (arb_pick),
    .pick_idx (arb_idx)
  );

  assign idx_oh = {{(N_REQ-1){1'b0}}, 1'b1} << idx_q;

`ifdef EEP_RDBK_VERIFY_EN
  logic err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Arbitration happens in the cycle before the grant becomes visible: in IDLE, and in DONE so
  // that a waiting requester is granted in the very first IDLE cycle after done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      ptr_q    <= '0;
      gidx_q   <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      r_w_n_q  <= 1'b1;
      bus_oe_q <= 1'b0;
      pmp_q    <= 1'b0;
`ifdef EEP_RDBK_VERIFY_EN
      err_q    <= 1'b0;
`endif
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
`ifdef EEP_RDBK_VERIFY_EN
      err_q  <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (|gnt_q) begin
            data_q   <= wdata[gidx_q*DW +: DW];
            idx_q    <= gidx_q;
            ptr_q    <= (gidx_q == LastIdx) ? '0 : gidx_q + 1'b1;
            state_q  <= StBus;
            busy_q   <= 1'b1;
            cs_n_q   <= 1'b0;
            r_w_n_q  <= 1'b0;
            bus_oe_q <= 1'b1;
          end else begin
            gnt_q  <= arb_pick;
            gidx_q <= arb_idx;
          end
        end
        StBus: begin
          timer_q  <= '0;
          state_q  <= StChrg;
          cs_n_q   <= 1'b1;
          r_w_n_q  <= 1'b1;
          bus_oe_q <= 1'b0;
          pmp_q    <= 1'b1;
        end
        StChrg: begin
          timer_q <= timer_q + 1'b1;
          if (timer_q == ChrgLast) begin
            pmp_q   <= 1'b0;
`ifdef EEP_RDBK_VERIFY_EN
            state_q <= StVrfy;
            cs_n_q  <= 1'b0;
`else
            state_q <= StDone;
            done_q  <= idx_oh;
`endif
          end
        end
`ifdef EEP_RDBK_VERIFY_EN
        StVrfy: begin
          state_q <= StDone;
          cs_n_q  <= 1'b0 | 1'b1;
          done_q  <= idx_oh;
          err_q   <= (eep_bus != data_q);
        end
`endif
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          gnt_q   <= arb_pick;
          gidx_q  <= arb_idx;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign eep_cs_n    = cs_n_q;
  assign eep_r_w_n   = r_w_n_q;
  assign chrg_pmp_en = pmp_q;
  assign eep_bus     = bus_oe_q ? data_q : {DW{1'bz}};

endmodule

// File: tb/tb_eep_wr_sched.sv
// Directed self-checking bench for eep_wr_sched with a 4-cycle charge window.
module tb_eep_wr_sched;

  localparam int unsigned NR = 4;
  localparam int unsigned DWB = 12;
  localparam int unsigned CC = 4;
`ifdef EEP_RDBK_VERIFY_EN
  localparam int VLAT = 1;
`else
  localparam int VLAT = 0;
`endif

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*DWB-1:0] wdata;
  logic [NR-1:0]     gnt;
  logic [NR-1:0]     done;
  logic              err;
  logic              busy;
  logic              eep_cs_n;
  logic              eep_r_w_n;
  wire  [DWB-1:0]    eep_bus;
  logic              chrg_pmp_en;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  eep_wr_sched #(
    .N_REQ       (NR),
    .DW          (DWB),
    .CHRG_CYCLES (CC)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .wdata       (wdata),
    .gnt         (gnt),
    .done        (done),
    .err         (err),
    .busy        (busy),
    .eep_cs_n    (eep_cs_n),
    .eep_r_w_n   (eep_r_w_n),
    .eep_bus     (eep_bus),
    .chrg_pmp_en (chrg_pmp_en)
  );

  // A released bus reads back as zero.
  for (genvar gi = 0; gi < DWB; gi++) begin : g_pd
    pulldown (eep_bus[gi]);
  end

`ifdef EEP_RDBK_VERIFY_EN
  logic [DWB-1:0] rd_val;
  assign eep_bus = (!eep_cs_n && eep_r_w_n) ? rd_val : {DWB{1'bz}};
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) tick();
  endtask

  task automatic wait_gnt(input int budget, input string tag);
    int n;
    n = 0;
    while (gnt == '0 && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(gnt != '0), 32'd1);
  endtask

  function automatic int oh2idx(input logic [NR-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  int g_idx[8];
  int g_cyc[8];
  int d_idx[8];
  int d_cyc[8];
  int ng;
  int nd;
  int t0;
  int t1c;
  int d1c;
  int pmp_cnt;
  logic bus_pend;

  initial begin
    wdata = '0;
    req   = '0;
    rst   = 1'b1;
`ifdef EEP_RDBK_VERIFY_EN
    rd_val = '0;
`endif
    tick();
    do_reset();

    // Reset state
    check_eq("rst_gnt", 32'(gnt), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);
    check_eq("rst_err", 32'(err), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_cs_n", 32'(eep_cs_n), 32'h1);
    check_eq("rst_r_w_n", 32'(eep_r_w_n), 32'h1);
    check_eq("rst_pmp", 32'(chrg_pmp_en), 32'h0);
    check_eq("rst_bus", 32'(eep_bus), 32'h0);

    // Single request
    wdata[0 +: DWB] = 12'hA5C;
    req = 4'b0001;
    rst = 1'b0;
    wait_gnt(20, "single_gnt_seen");
    check_eq("single_gnt", 32'(gnt), 32'h1);
    check_eq("single_gnt_busy", 32'(busy), 32'h0);
    req = '0;
    tick();
    check_eq("single_bus_cs_n", 32'(eep_cs_n), 32'h0);
    check_eq("single_bus_r_w_n", 32'(eep_r_w_n), 32'h0);
    check_eq("single_bus_data", 32'(eep_bus), 32'hA5C);
    check_eq("single_bus_busy", 32'(busy), 32'h1);
    check_eq("single_bus_pmp", 32'(chrg_pmp_en), 32'h0);
    pmp_cnt = 0;
    for (int i = 0; i < CC; i++) begin
      tick();
      if (chrg_pmp_en && eep_cs_n) pmp_cnt++;
    end
    check_eq("single_pmp_cycles", 32'(pmp_cnt), 32'(CC));
    repeat (VLAT) tick();
    tick();
    check_eq("single_done", 32'(done), 32'h1);
    check_eq("single_done_pmp", 32'(chrg_pmp_en), 32'h0);
    check_eq("single_err", 32'(err), 32'h0);
    tick();
    check_eq("single_idle_busy", 32'(busy), 32'h0);
    check_eq("single_idle_done", 32'(done), 32'h0);

    // All requesting
    do_reset();
    wdata = {12'hD04, 12'hC03, 12'hB02, 12'hA01};
    req = 4'b1111;
    rst = 1'b0;
    ng = 0;
    nd = 0;
    bus_pend = 1'b0;
    for (int i = 0; i < 5 * (7 + VLAT) + 2; i++) begin
      tick();
      if (bus_pend) begin
        check_eq("all_bus_data", 32'(eep_bus), 32'(wdata[g_idx[ng-1]*DWB +: DWB]));
        bus_pend = 1'b0;
      end
      if (gnt != '0 && ng < 8) begin
        check_eq("all_gnt_onehot", 32'($countones(gnt)), 32'd1);
        g_idx[ng] = oh2idx(gnt);
        g_cyc[ng] = cyc;
        ng++;
        bus_pend = 1'b1;
      end
      if (done != '0 && nd < 8) begin
        d_idx[nd] = oh2idx(done);
        d_cyc[nd] = cyc;
        nd++;
      end
    end
    check_eq("all_gnt_count", 32'(ng >= 5), 32'd1);
    check_eq("all_done_count", 32'(nd >= 5), 32'd1);
    for (int i = 0; i < 5 && i < ng && i < nd; i++) begin
      check_eq("all_order", 32'(g_idx[i]), 32'(i % NR));
      check_eq("all_done_idx", 32'(d_idx[i]), 32'(g_idx[i]));
      check_eq("all_done_lat", 32'(d_cyc[i] - g_cyc[i]), 32'(6 + VLAT));
      if (i > 0) check_eq("all_gnt_gap", 32'(g_cyc[i] - g_cyc[i-1]), 32'(7 + VLAT));
    end

    // Late request raised during the pump window of requester 1
    do_reset();
    wdata = {12'h000, 12'h222, 12'h111, 12'h100};
    req = 4'b0011;
    rst = 1'b0;
    wait_gnt(20, "late_g0_seen");
    check_eq("late_g0", 32'(gnt), 32'h1);
    tick();
    wait_gnt(20, "late_g1_seen");
    check_eq("late_g1", 32'(gnt), 32'h2);
    t1c = cyc;
    req[1] = 1'b0;
    repeat (3) tick();
    check_eq("late_in_chrg", 32'(chrg_pmp_en), 32'h1);
    req[2] = 1'b1;
    d1c = -1;
    for (int i = 0; i < 20 && gnt == '0; i++) begin
      tick();
      if (done == 4'b0010) d1c = cyc;
    end
    check_eq("late_g2", 32'(gnt), 32'h4);
    check_eq("late_gap", 32'(cyc - t1c), 32'(7 + VLAT));
    check_eq("late_done1", 32'(d1c - t1c), 32'(6 + VLAT));
    req[2] = 1'b0;
    tick();
    wait_gnt(20, "late_g0b_seen");
    check_eq("late_g0b", 32'(gnt), 32'h1);
    req = '0;

    // Reset in the middle of the pump window
    do_reset();
    wdata = '0;
    wdata[DWB +: DWB] = 12'h3C3;
    req = 4'b0010;
    rst = 1'b0;
    wait_gnt(20, "mid_gnt_seen");
    check_eq("mid_gnt", 32'(gnt), 32'h2);
    req = '0;
    tick();
    check_eq("mid_bus_drv", 32'(eep_bus), 32'h3C3);
    repeat (3) tick();
    check_eq("mid_pmp_on", 32'(chrg_pmp_en), 32'h1);
    rst = 1'b1;
    tick();
    check_eq("mid_pmp_off", 32'(chrg_pmp_en), 32'h0);
    check_eq("mid_busy", 32'(busy), 32'h0);
    check_eq("mid_cs_n", 32'(eep_cs_n), 32'h1);
    check_eq("mid_bus_rel", 32'(eep_bus), 32'h0);
    check_eq("mid_done0", 32'(done), 32'h0);
    tick();
    check_eq("mid_done1", 32'(done), 32'h0);
    req = 4'b0011;
    rst = 1'b0;
    wait_gnt(20, "mid_ptr_seen");
    check_eq("mid_ptr", 32'(gnt), 32'h1);
    req = '0;

`ifdef EEP_RDBK_VERIFY_EN
    // Read-back mismatch, then match
    do_reset();
    wdata = '0;
    wdata[0 +: DWB] = 12'hA5C;
    rd_val = 12'hA5D;
    req = 4'b0001;
    rst = 1'b0;
    wait_gnt(20, "vrfy_gnt_seen");
    req = '0;
    repeat (2 + CC) tick();
    check_eq("vrfy_cs_n", 32'(eep_cs_n), 32'h0);
    check_eq("vrfy_r_w_n", 32'(eep_r_w_n), 32'h1);
    tick();
    check_eq("vrfy_done", 32'(done), 32'h1);
    check_eq("vrfy_err_bad", 32'(err), 32'h1);
    tick();
    rd_val = 12'hA5C;
    req = 4'b0001;
    wait_gnt(20, "vrfy_gnt2_seen");
    req = '0;
    repeat (3 + CC) tick();
    check_eq("vrfy_done2", 32'(done), 32'h1);
    check_eq("vrfy_err_ok", 32'(err), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
